// File: rtl/fpu_seq_if.sv
// -----------------------------------------------------------------------------
// fpu_seq_if
// Command/completion bundle between the CPU-side FPU register file and the
// add/sub sequencer.
//
//   start      CPU -> FPU  one-cycle pulse, opcode register written
//   op         CPU -> FPU  4'h0 add, 4'h1 sub, 4'h2 mul, 4'h3 div, rest reserved
//   operand_a  CPU -> FPU  IEEE-754 single A
//   operand_b  CPU -> FPU  IEEE-754 single B
//   end_ack    CPU -> FPU  completion acknowledge
//   busy       FPU -> CPU  operation in progress
//   cmd_end    FPU -> CPU  completion / interrupt level
//   result     FPU -> CPU  packed result
//   status     FPU -> CPU  {0, sign, underflow, unsupported, invalid,
//                           overflow, zero, done}
//
// master: CPU side.  slave: sequencer side.
// -----------------------------------------------------------------------------
interface fpu_seq_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        end_ack;
   logic        busy;
   logic        cmd_end;
   logic [31:0] result;
   logic [7:0]  status;

   modport master (
      output start, op, operand_a, operand_b, end_ack,
      input  busy, cmd_end, result, status
   );

   modport slave (
      input  start, op, operand_a, operand_b, end_ack,
      output busy, cmd_end, result, status
   );
endinterface

// File: rtl/fpu_seq.sv
// -----------------------------------------------------------------------------
// fpu_seq
// Multi-cycle single-precision add/sub sequencer. A narrow datapath is stepped
// through unpack, align (1 bit per cycle), add/sub, normalize (1 bit per
// cycle), round and pack. Denormal inputs are flushed to zero and results
// whose exponent would drop to zero are flushed to signed zero.
//
// Ports:
//   clk   system clock
//   arst  reset, synchronous, active-high
//   bus   fpu_seq_if.slave (start/op/operands/end_ack in,
//         busy/cmd_end/result/status out)
//
// Parameters:
//   ALIGN_CAP  exponent difference at or above which alignment collapses to
//              one cycle (shifted mantissa becomes sticky only)
//
// Build option:
//   FPU_ROUND_NEAREST_EN  defined   -> round to nearest even (guard/round/sticky)
//                         undefined -> truncation
// -----------------------------------------------------------------------------
module fpu_seq #(
   parameter int ALIGN_CAP = 26
) (
   input  logic     clk,
   input  logic     arst,
   fpu_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      ALIGN,
      ADDSUB,
      NORM,
      ROUND,
      DONE
   } state_t;

   localparam logic [7:0]  CAP_W = 8'(ALIGN_CAP);
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   // r_flags bit positions (status[5:1])
   localparam int F_ZERO = 0;
   localparam int F_OVF  = 1;
   localparam int F_INV  = 2;
   localparam int F_UNS  = 3;
   localparam int F_UNF  = 4;

   state_t      r_state,  w_state_next;
   logic [3:0]  r_op,     w_op_next;
   logic [31:0] r_a,      w_a_next;
   logic [31:0] r_b,      w_b_next;
   logic        r_sign_x, w_sign_x_next;   // larger-exponent operand
   logic        r_sign_y, w_sign_y_next;   // smaller-exponent operand
   logic [26:0] r_mx,     w_mx_next;       // {hidden, frac[22:0], g, r, s}
   logic [26:0] r_my,     w_my_next;
   logic [9:0]  r_exp,    w_exp_next;
   logic [7:0]  r_cnt,    w_cnt_next;      // remaining alignment shifts
   logic [27:0] r_sum,    w_sum_next;      // {carry, hidden, frac, g, r, s}
   logic        r_sign,   w_sign_next;
   logic [31:0] r_result, w_result_next;
   logic [4:0]  r_flags,  w_flags_next;
   logic        r_done,   w_done_next;

   // ---------------------------------------------------------------- unpack
   logic        w_sa, w_sb;
   logic [7:0]  w_ea, w_eb;
   logic [22:0] w_fa, w_fb;
   logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic        w_a_big;
   logic [7:0]  w_d;

   assign w_sa    = r_a[31];
   assign w_sb    = r_b[31] ^ (r_op == 4'h1);   // subtract = add with B negated
   assign w_ea    = r_a[30:23];
   assign w_eb    = r_b[30:23];
   assign w_fa    = r_a[22:0];
   assign w_fb    = r_b[22:0];
   assign w_za    = (w_ea == 8'd0);
   assign w_zb    = (w_eb == 8'd0);
   assign w_ia    = (w_ea == 8'hFF) && (w_fa == 23'd0);
   assign w_ib    = (w_eb == 8'hFF) && (w_fb == 23'd0);
   assign w_na    = (w_ea == 8'hFF) && (w_fa != 23'd0);
   assign w_nb    = (w_eb == 8'hFF) && (w_fb != 23'd0);
   assign w_a_big = (w_ea >= w_eb);
   assign w_d     = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);

   // ---------------------------------------------------------------- add/sub
   logic [27:0] w_sum_add;
   logic        w_x_ge;
   logic [26:0] w_diff;

   assign w_sum_add = {1'b0, r_mx} + {1'b0, r_my};
   // With d=0 the "smaller" operand may still hold the larger magnitude.
   assign w_x_ge    = (r_mx >= r_my);
   assign w_diff    = w_x_ge ? (r_mx - r_my) : (r_my - r_mx);

   // ---------------------------------------------------------------- round
   logic [23:0] w_mant24;
   logic        w_up;
   logic [24:0] w_mant25;
   logic [9:0]  w_exp_rnd;
   logic [22:0] w_frac_rnd;

   assign w_mant24 = r_sum[26:3];

`ifdef FPU_ROUND_NEAREST_EN
   logic w_guard;
   logic w_rs;
   assign w_guard = r_sum[2];
   assign w_rs    = r_sum[1] | r_sum[0];
   // Ties go to the even mantissa.
   assign w_up    = w_guard & (w_rs | w_mant24[0]);
`else
   assign w_up    = 1'b0;
`endif

   assign w_mant25   = {1'b0, w_mant24} + {24'd0, w_up};
   // A rounding carry leaves 1.000..0, so the fraction is zero either way.
   assign w_exp_rnd  = w_mant25[24] ? (r_exp + 10'd1) : r_exp;
   assign w_frac_rnd = w_mant25[24] ? w_mant25[23:1] : w_mant25[22:0];

   // ---------------------------------------------------------------- outputs
   assign bus.busy    = (r_state != IDLE) && (r_state != DONE);
   assign bus.cmd_end = (r_state == DONE);
   assign bus.result  = r_result;
   assign bus.status  = {1'b0, r_done & r_result[31], r_flags, r_done};

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_next  = r_state;
      w_op_next     = r_op;
      w_a_next      = r_a;
      w_b_next      = r_b;
      w_sign_x_next = r_sign_x;
      w_sign_y_next = r_sign_y;
      w_mx_next     = r_mx;
      w_my_next     = r_my;
      w_exp_next    = r_exp;
      w_cnt_next    = r_cnt;
      w_sum_next    = r_sum;
      w_sign_next   = r_sign;
      w_result_next = r_result;
      w_flags_next  = r_flags;
      w_done_next   = r_done;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_op_next    = bus.op;
               w_a_next     = bus.operand_a;
               w_b_next     = bus.operand_b;
               w_flags_next = 5'd0;
               w_done_next  = 1'b0;
               w_state_next = UNPACK;
            end
         end

         UNPACK: begin
            w_state_next = DONE;
            if (r_op > 4'h1) begin
               w_result_next       = 32'd0;
               w_flags_next[F_UNS] = 1'b1;
            end else if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sb))) begin
               w_result_next       = QNAN;
               w_flags_next[F_INV] = 1'b1;
            end else if (w_ia) begin
               w_result_next = {w_sa, 8'hFF, 23'd0};
            end else if (w_ib) begin
               w_result_next = {w_sb, 8'hFF, 23'd0};
            end else if (w_za && w_zb) begin
               w_result_next = {w_sa & w_sb, 31'd0};
            end else if (w_za) begin
               w_result_next = {w_sb, r_b[30:0]};
            end else if (w_zb) begin
               w_result_next = r_a;
            end else begin
               // Ordinary operands: put the larger exponent in x.
               if (w_a_big) begin
                  w_sign_x_next = w_sa;
                  w_sign_y_next = w_sb;
                  w_mx_next     = {1'b1, w_fa, 3'b000};
                  w_my_next     = {1'b1, w_fb, 3'b000};
                  w_exp_next    = {2'b00, w_ea};
               end else begin
                  w_sign_x_next = w_sb;
                  w_sign_y_next = w_sa;
                  w_mx_next     = {1'b1, w_fb, 3'b000};
                  w_my_next     = {1'b1, w_fa, 3'b000};
                  w_exp_next    = {2'b00, w_eb};
               end
               w_cnt_next   = w_d;
               w_state_next = (w_d == 8'd0) ? ADDSUB : ALIGN;
            end
         end

         ALIGN: begin
            if (r_cnt >= CAP_W) begin
               // Everything shifts out: only the sticky bit survives.
               w_my_next    = 27'd1;
               w_state_next = ADDSUB;
            end else begin
               w_my_next  = {1'b0, r_my[26:2], r_my[1] | r_my[0]};
               w_cnt_next = r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  w_state_next = ADDSUB;
               end
            end
         end

         ADDSUB: begin
            w_state_next = NORM;
            if (r_sign_x == r_sign_y) begin
               w_sum_next  = w_sum_add;
               w_sign_next = r_sign_x;
            end else if (r_mx == r_my) begin
               w_result_next        = 32'd0;
               w_flags_next[F_ZERO] = 1'b1;
               w_state_next         = DONE;
            end else begin
               w_sum_next  = {1'b0, w_diff};
               w_sign_next = w_x_ge ? r_sign_x : r_sign_y;
            end
         end

         NORM: begin
            if (r_sum[27]) begin
               w_sum_next   = {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
               w_exp_next   = r_exp + 10'd1;
               w_state_next = ROUND;
            end else if (r_sum[26]) begin
               w_state_next = ROUND;
            end else if (r_exp <= 10'd1) begin
               // One more shift would take the exponent to zero: flush.
               w_result_next        = {r_sign, 31'd0};
               w_flags_next[F_UNF]  = 1'b1;
               w_flags_next[F_ZERO] = 1'b1;
               w_state_next         = DONE;
            end else begin
               w_sum_next = {r_sum[26:0], 1'b0};
               w_exp_next = r_exp - 10'd1;
               if (r_sum[25]) begin
                  w_state_next = ROUND;
               end
            end
         end

         ROUND: begin
            w_state_next = DONE;
            if (w_exp_rnd >= 10'd255) begin
               w_result_next       = {r_sign, 8'hFF, 23'd0};
               w_flags_next[F_OVF] = 1'b1;
            end else begin
               w_result_next = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
            end
         end

         DONE: begin
            // A start arriving with the ack is dropped: we leave via IDLE.
            if (bus.end_ack) begin
               w_state_next = IDLE;
            end
         end

         default: w_state_next = IDLE;
      endcase

      if (w_state_next == DONE) begin
         w_done_next = 1'b1;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (arst) begin
         r_state  <= IDLE;
         r_op     <= 4'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_sign_x <= 1'b0;
         r_sign_y <= 1'b0;
         r_mx     <= 27'd0;
         r_my     <= 27'd0;
         r_exp    <= 10'd0;
         r_cnt    <= 8'd0;
         r_sum    <= 28'd0;
         r_sign   <= 1'b0;
         r_result <= 32'd0;
         r_flags  <= 5'd0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_op     <= w_op_next;
         r_a      <= w_a_next;
         r_b      <= w_b_next;
         r_sign_x <= w_sign_x_next;
         r_sign_y <= w_sign_y_next;
         r_mx     <= w_mx_next;
         r_my     <= w_my_next;
         r_exp    <= w_exp_next;
         r_cnt    <= w_cnt_next;
         r_sum    <= w_sum_next;
         r_sign   <= w_sign_next;
         r_result <= w_result_next;
         r_flags  <= w_flags_next;
         r_done   <= w_done_next;
      end
   end

endmodule

// File: tb/tb_fpu_seq.sv
// -----------------------------------------------------------------------------
// tb_fpu_seq
// Self-checking bench for fpu_seq: directed cases plus randomized add/sub
// traffic compared against an exact-arithmetic reference model (operands
// expanded into wide integers, summed exactly, then normalized and rounded).
// Honours FPU_ROUND_NEAREST_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_fpu_seq;

   logic clk = 1'b0;
   logic arst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;
   bit   busy_ok;

   fpu_seq_if bus();

   fpu_seq #(.ALIGN_CAP(26)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

`ifdef FPU_ROUND_NEAREST_EN
   localparam logic [31:0] D24_RES = 32'h3F80_0001;
`else
   localparam logic [31:0] D24_RES = 32'h3F80_0000;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Exact reference: returns {status, result}.
   function automatic logic [39:0] ref_model(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic        sa, sb, sr, za, zb, ia, ib, na, nb, g, rest, up;
      int          ea, eb, emin, p, be;
      logic [22:0] fa, fb;
      logic [299:0] va, vb, mag;
      logic [24:0] m;
      logic [31:0] r;
      if (op > 4'h1) return {8'h11, 32'h0};
      sa = a[31]; sb = b[31] ^ (op == 4'h1);
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      fa = a[22:0]; fb = b[22:0];
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
      na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
      if (na || nb || (ia && ib && sa != sb)) return {8'h09, 32'h7FC0_0000};
      if (ia || ib || za || zb) begin
         if (ia)            r = {sa, 8'hFF, 23'd0};
         else if (ib)       r = {sb, 8'hFF, 23'd0};
         else if (za && zb) r = {sa & sb, 31'd0};
         else if (za)       r = {sb, b[30:0]};
         else               r = a;
         return {1'b0, r[31], 6'b000001, r};
      end
      emin = (ea < eb) ? ea : eb;
      va = {276'd0, 1'b1, fa} << (ea - emin);
      vb = {276'd0, 1'b1, fb} << (eb - emin);
      if (sa == sb)     begin mag = va + vb; sr = sa; end
      else if (va > vb) begin mag = va - vb; sr = sa; end
      else if (vb > va) begin mag = vb - va; sr = sb; end
      else return {8'h03, 32'h0};
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      be = p + emin - 23;
      if (be <= 0) return {1'b0, sr, 6'b100011, sr, 31'd0};
      g = 1'b0; rest = 1'b0;
      if (p >= 23) m = 25'(mag >> (p - 23));
      else         m = 25'(mag << (23 - p));
      if (p >= 24) g = mag[p - 24];
      if (p >= 25) rest = |(mag & ((300'd1 << (p - 24)) - 300'd1));
`ifdef FPU_ROUND_NEAREST_EN
      up = g & (rest | m[0]);
`else
      up = 1'b0;
`endif
      m = m + {24'd0, up};
      if (m[24]) begin m = m >> 1; be++; end
      if (be >= 255) return {1'b0, sr, 6'b000101, sr, 8'hFF, 23'd0};
      r = {sr, be[7:0], m[22:0]};
      return {1'b0, sr, 6'b000001, r};
   endfunction

   // Presents a start pulse; returns at the negedge after the sampling edge.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts edges since the start-sampling edge until cmd_end, bounded.
   task automatic wait_done(output int n, output bit b_ok);
      n = 1; b_ok = 1'b1;
      while (!bus.cmd_end && n < 300) begin
         if (!bus.busy) b_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk("cmd_end_seen", 32'(bus.cmd_end), 32'd1);
      chk("busy_in_done", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_ack();
      bus.end_ack = 1'b1;
      @(negedge clk);
      bus.end_ack = 1'b0;
      chk("cmd_end_after_ack", 32'(bus.cmd_end), 32'd0);
   endtask

   task automatic run_txn(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      logic [39:0] e;
      e = ref_model(op, a, b);
      start_op(op, a, b);
      wait_done(lat, busy_ok);
      chk({tag, "_result"}, bus.result, e[31:0]);
      chk({tag, "_status"}, 32'(bus.status), 32'(e[39:32]));
      $display("txn %s op=%h a=%h b=%h res=%h st=%h lat=%0d",
               tag, op, a, b, bus.result, bus.status, lat);
      do_ack();
   endtask

   initial begin
      int ea, eb, k;
      logic [3:0]  op;
      logic [31:0] a, b;

      bus.start = 1'b0; bus.op = 4'd0; bus.operand_a = 32'd0;
      bus.operand_b = 32'd0; bus.end_ack = 1'b0;
      arst = 1'b1;
      repeat (3) @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      chk("rst_busy",    32'(bus.busy),    32'd0);
      chk("rst_cmd_end", 32'(bus.cmd_end), 32'd0);
      chk("rst_status",  32'(bus.status),  32'd0);
      chk("rst_result",  bus.result,       32'd0);

      // 1.0 + 1.0: cmd_end on the 5th edge, busy in between
      start_op(4'h0, 32'h3F80_0000, 32'h3F80_0000);
      wait_done(lat, busy_ok);
      chk("one_plus_one_lat",  32'(lat), 32'd5);
      chk("one_plus_one_busy", 32'(busy_ok), 32'd1);
      chk("one_plus_one_res",  bus.result, 32'h4000_0000);
      chk("one_plus_one_st",   32'(bus.status), 32'h01);
      $display("txn one_plus_one res=%h st=%h lat=%0d", bus.result, bus.status, lat);
      do_ack();

      // exact cancellation
      start_op(4'h1, 32'h3FC0_0000, 32'h3FC0_0000);
      wait_done(lat, busy_ok);
      chk("cancel_res", bus.result, 32'h0);
      chk("cancel_st",  32'(bus.status), 32'h03);
      $display("txn cancel res=%h st=%h", bus.result, bus.status);
      do_ack();

      // overflow to infinity
      start_op(4'h0, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
      wait_done(lat, busy_ok);
      chk("ovf_res", bus.result, 32'h7F80_0000);
      chk("ovf_st",  32'(bus.status), 32'h05);
      $display("txn ovf res=%h st=%h", bus.result, bus.status);
      do_ack();

      // inf + -inf
      start_op(4'h0, 32'h7F80_0000, 32'hFF80_0000);
      wait_done(lat, busy_ok);
      chk("inv_res", bus.result, 32'h7FC0_0000);
      chk("inv_st",  32'(bus.status), 32'h09);
      $display("txn inv res=%h st=%h", bus.result, bus.status);
      do_ack();

      // unsupported mul
      start_op(4'h2, 32'h4040_0000, 32'h4000_0000);
      wait_done(lat, busy_ok);
      chk("mul_lat", 32'(lat), 32'd2);
      chk("mul_res", bus.result, 32'h0);
      chk("mul_st",  32'(bus.status), 32'h11);
      $display("txn mul res=%h st=%h lat=%0d", bus.result, bus.status, lat);
      do_ack();

      // d=24, rounding-sensitive
      start_op(4'h0, 32'h3F80_0000, 32'h33C0_0000);
      wait_done(lat, busy_ok);
      chk("d24_lat", 32'(lat), 32'd29);
      chk("d24_res", bus.result, D24_RES);
      $display("txn d24 res=%h st=%h lat=%0d", bus.result, bus.status, lat);
      do_ack();

      // start during ALIGN is ignored
      start_op(4'h0, 32'h3F80_0000, 32'h33C0_0000);
      repeat (3) @(negedge clk);
      bus.op = 4'h1; bus.operand_a = 32'h4000_0000; bus.operand_b = 32'h4000_0000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, busy_ok);
      chk("midstart_res", bus.result, D24_RES);
      $display("txn midstart res=%h st=%h", bus.result, bus.status);
      do_ack();

      // reset during NORM (1.0 - 0.99999994 needs a long normalize)
      start_op(4'h1, 32'h3F80_0000, 32'h3F7F_FFFF);
      repeat (5) @(negedge clk);
      chk("norm_busy", 32'(bus.busy), 32'd1);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      chk("abort_busy",    32'(bus.busy),    32'd0);
      chk("abort_cmd_end", 32'(bus.cmd_end), 32'd0);
      chk("abort_status",  32'(bus.status),  32'd0);
      $display("txn abort busy=%b cmd_end=%b st=%h", bus.busy, bus.cmd_end, bus.status);
      run_txn("after_abort", 4'h0, 32'h3F80_0000, 32'h4000_0000);
      chk("after_abort_val", bus.result, 32'h4040_0000);
      run_txn("tiny_diff", 4'h1, 32'h3F80_0000, 32'h3F7F_FFFF);

      // ack and start together: start dropped
      start_op(4'h0, 32'h3F80_0000, 32'h3F80_0000);
      wait_done(lat, busy_ok);
      bus.end_ack = 1'b1; bus.start = 1'b1;
      bus.operand_a = 32'h4100_0000; bus.operand_b = 32'h4100_0000;
      @(negedge clk);
      bus.end_ack = 1'b0; bus.start = 1'b0;
      chk("ackstart_cmd_end", 32'(bus.cmd_end), 32'd0);
      chk("ackstart_busy",    32'(bus.busy),    32'd0);
      @(negedge clk);
      chk("ackstart_busy2",   32'(bus.busy),    32'd0);
      chk("ackstart_result",  bus.result,       32'h4000_0000);
      chk("ackstart_status",  32'(bus.status),  32'h01);
      $display("txn ackstart busy=%b res=%h st=%h", bus.busy, bus.result, bus.status);

      // randomized traffic
      for (int t = 0; t < 80; t++) begin
         ea = int'($urandom_range(1, 254));
         k  = int'($urandom_range(0, 11));
         case (k)
            0:       eb = 0;
            1:       eb = 255;
            2:       eb = int'($urandom_range(1, 254));
            default: eb = ea + int'($urandom_range(0, 56)) - 28;
         endcase
         if (eb < 0)   eb = 1;
         if (eb > 255) eb = 254;
         if (k > 2 && eb == 0)   eb = 1;
         if (k > 2 && eb == 255) eb = 254;
         a = {1'($urandom), 8'(ea), 23'($urandom)};
         b = {1'($urandom), 8'(eb), 23'($urandom)};
         if (k == 1 && $urandom_range(0, 1) == 1) b[22:0] = 23'd0;
         if (k == 3) b = {1'($urandom), a[30:3], 3'($urandom)};
         if (k == 4) a = {a[31], 8'hFF, 23'd0};
         case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 4'h0;
            4, 5, 6, 7: op = 4'h1;
            8:          op = 4'h2;
            default:    op = 4'($urandom_range(3, 15));
         endcase
         run_txn($sformatf("rnd%0d", t), op, a, b);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
